// File: rtl/systolic_mac_pe.sv
// Systolic multiply-accumulate processing element for one matrix row.
// Samples are multiplied by a runtime-writable coefficient chosen from the
// sample's position in an NTAPS-word window. The multiply is a serial
// shift-add over operand magnitudes. Products accumulate across the window,
// and the sum is scaled by FRAC bits and saturated to WORDLENGTH bits.
//
// Handshakes: a transfer happens on any rising edge where valid && ready are
// both high. in_ready and out_valid are decoded from the state register only,
// so no combinational path runs from in_valid/out_ready to any output. A
// source must hold its word stable until the transfer. Once out_valid is
// high, the output stays stable until the transfer.
module systolic_mac_pe #(
    parameter int WORDLENGTH = 16,
    parameter int IDXW       = 3,
    parameter int FRAC       = 14
) (
    input  logic                  clk30x,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [WORDLENGTH-1:0] in_word,
    output logic                  in_ready,
    input  logic [IDXW-1:0]       start_index,
    input  logic                  coeff_we,
    input  logic [IDXW-1:0]       coeff_addr,
    input  logic [WORDLENGTH-1:0] coeff_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORDLENGTH-1:0] out_word,
    output logic                  out_last,
    output logic                  sat_flag,
    output logic [1:0]            dbg_state
);

    localparam int NTAPS = 2 ** IDXW;
    localparam int PW    = 2 * WORDLENGTH;
    localparam int AW    = PW + IDXW;
    localparam int BCW   = $clog2(WORDLENGTH + 1);

    localparam logic signed [AW-1:0] MAXV = {{(AW-WORDLENGTH+1){1'b0}}, {(WORDLENGTH-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-WORDLENGTH+1){1'b1}}, {(WORDLENGTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_ACC  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [WORDLENGTH-1:0] coeff [NTAPS];
    logic [IDXW-1:0]       word_index;
    logic [IDXW-1:0]       pos;
    logic [IDXW-1:0]       pos_now;
    logic [PW-1:0]         a_sh;      // multiplicand magnitude, shifted left each cycle
    logic [WORDLENGTH-1:0] b_sh;      // multiplier magnitude, shifted right each cycle
    logic [PW-1:0]         prod_mag;
    logic                  prod_neg;
    logic [BCW-1:0]        bit_cnt;
    logic signed [AW-1:0]  acc;

    logic [WORDLENGTH-1:0] in_mag;
    logic [WORDLENGTH-1:0] c_sel;
    logic [WORDLENGTH-1:0] c_mag;
    logic signed [PW-1:0]  product;
    logic signed [AW-1:0]  acc_next;
    logic signed [AW-1:0]  scaled;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_OUT);
    assign dbg_state = state;

    // Window position of the word being accepted, and the operand magnitudes.
    // The magnitude of the most negative value fits in WORDLENGTH bits unsigned.
    always_comb begin
        pos_now = word_index - start_index;
        c_sel   = coeff[pos_now];
        in_mag  = in_word[WORDLENGTH-1] ? (~in_word + 1'b1) : in_word;
        c_mag   = c_sel[WORDLENGTH-1] ? (~c_sel + 1'b1) : c_sel;
    end

    // Signed product, accumulator update and the scaled, saturated result.
    always_comb begin
        product  = prod_neg ? -$signed(prod_mag) : $signed(prod_mag);
        acc_next = (pos == '0) ? AW'(product) : acc + AW'(product);
        scaled   = acc_next >>> FRAC;
    end

    // State register.
    always_ff @(posedge clk30x) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (in_valid) state_next = S_MULT;
            S_MULT: if (bit_cnt == BCW'(WORDLENGTH - 1)) state_next = S_ACC;
            S_ACC:  state_next = S_OUT;
            S_OUT:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // The coefficient bank is writable in every state. An acceptance on the
    // same edge reads the old value.
    always_ff @(posedge clk30x) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) coeff[i] <= '0;
        end else if (coeff_we) begin
            coeff[coeff_addr] <= coeff_data;
        end
    end

    // Datapath: latch operands on acceptance, shift-add in MULT, and in ACC
    // accumulate and register the outputs.
    always_ff @(posedge clk30x) begin
        if (reset) begin
            word_index <= '0;
            pos        <= '0;
            a_sh       <= '0;
            b_sh       <= '0;
            prod_mag   <= '0;
            prod_neg   <= 1'b0;
            bit_cnt    <= '0;
            acc        <= '0;
            out_word   <= '0;
            out_last   <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh     <= {{WORDLENGTH{1'b0}}, c_mag};
                        b_sh     <= in_mag;
                        prod_neg <= in_word[WORDLENGTH-1] ^ c_sel[WORDLENGTH-1];
                        prod_mag <= '0;
                        pos      <= pos_now;
                        bit_cnt  <= '0;
                    end
                end
                S_MULT: begin
                    if (b_sh[0]) prod_mag <= prod_mag + a_sh;
                    a_sh    <= a_sh << 1;
                    b_sh    <= b_sh >> 1;
                    bit_cnt <= bit_cnt + BCW'(1);
                end
                S_ACC: begin
                    acc        <= acc_next;
                    word_index <= word_index + IDXW'(1);
                    out_last   <= (pos == IDXW'(NTAPS - 1));
                    if (scaled > MAXV) begin
                        out_word <= MAXV[WORDLENGTH-1:0];
                        sat_flag <= 1'b1;
                    end else if (scaled < MINV) begin
                        out_word <= MINV[WORDLENGTH-1:0];
                        sat_flag <= 1'b1;
                    end else begin
                        out_word <= scaled[WORDLENGTH-1:0];
                        sat_flag <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Directed testbench for systolic_mac_pe with default parameters
// (W=16, FRAC=14, IDXW=3; 16384 represents 1.0).
module tb_systolic_mac_pe;

    logic        clk30x = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_word;
    logic        in_ready;
    logic [2:0]  start_index;
    logic        coeff_we;
    logic [2:0]  coeff_addr;
    logic [15:0] coeff_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_word;
    logic        out_last;
    logic        sat_flag;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    systolic_mac_pe #(.WORDLENGTH(16), .IDXW(3), .FRAC(14)) dut (
        .clk30x      (clk30x),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_word     (in_word),
        .in_ready    (in_ready),
        .start_index (start_index),
        .coeff_we    (coeff_we),
        .coeff_addr  (coeff_addr),
        .coeff_data  (coeff_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_word    (out_word),
        .out_last    (out_last),
        .sat_flag    (sat_flag),
        .dbg_state   (dbg_state)
    );

    // Clock: 10-unit period.
    always #5 clk30x = ~clk30x;

    // ---------------- driver tasks ----------------
    task automatic hw_reset;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_word     = '0;
        coeff_we    = 1'b0;
        coeff_addr  = '0;
        coeff_data  = '0;
        out_ready   = 1'b1;
        start_index = '0;
        repeat (2) @(posedge clk30x);
        #1 reset = 1'b0;
    endtask

    task automatic write_coeff(input logic [2:0] a, input logic [15:0] d);
        coeff_we   = 1'b1;
        coeff_addr = a;
        coeff_data = d;
        @(posedge clk30x);
        #1 coeff_we = 1'b0;
    endtask

    // Waits for in_ready, then presents the word for exactly one acceptance edge.
    task automatic accept(input logic [15:0] w);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk30x);
            #1 n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        end
        in_valid = 1'b1;
        in_word  = w;
        @(posedge clk30x);
        #1 in_valid = 1'b0;
    endtask

    // Counts edges until out_valid is seen. The count is bounded.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk30x);
            #1 lat++;
        end
        if (!out_valid) begin
            total++;
            bad++;
            $display("FAIL out_timeout: out_valid=%0b after %0d cycles, required 1", out_valid, lat);
        end
    endtask

    // Consumes the output with out_ready held high.
    task automatic consume;
        out_ready = 1'b1;
        @(posedge clk30x);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        hw_reset();
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        total++;
        if (out_word !== 16'd0 || out_last !== 1'b0 || sat_flag !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: word=%0h last=%0b sat=%0b want 0/0/0", out_word, out_last, sat_flag);
        end
    endtask

    task automatic test_unity_window;
        int lat;
        hw_reset();
        for (int a = 0; a < 8; a++) write_coeff(a[2:0], 16'd16384);
        for (int k = 1; k <= 9; k++) begin
            accept(16'd100);
            wait_out(lat);
            total++;
            if (lat !== 17) begin bad++; $display("FAIL unity_latency[%0d]: got %0d want 17", k, lat); end
            total++;
            if (out_word !== 16'(100 * ((k - 1) % 8 + 1))) begin
                bad++;
                $display("FAIL unity_word[%0d]: got %0d want %0d", k, out_word, 100 * ((k - 1) % 8 + 1));
            end
            total++;
            if (out_last !== (k == 8)) begin bad++; $display("FAIL unity_last[%0d]: got %0b want %0b", k, out_last, (k == 8)); end
            consume();
        end
    endtask

    task automatic test_start_offset;
        int lat;
        logic [15:0] exp_w [3];
        logic        exp_l [3];
        logic [15:0] smp   [3];
        exp_w = '{16'd500, 16'd500, 16'd7};
        exp_l = '{1'b0, 1'b1, 1'b0};
        smp   = '{16'd1000, 16'd50, 16'd7};
        hw_reset();
        write_coeff(3'd6, 16'd8192);
        write_coeff(3'd0, 16'd16384);
        start_index = 3'd2;
        for (int k = 0; k < 3; k++) begin
            accept(smp[k]);
            wait_out(lat);
            total++;
            if (out_word !== exp_w[k] || out_last !== exp_l[k]) begin
                bad++;
                $display("FAIL offset[%0d]: word=%0d last=%0b want %0d/%0b", k, out_word, out_last, exp_w[k], exp_l[k]);
            end
            consume();
        end
    endtask

    task automatic test_signed_sat;
        int lat;
        hw_reset();
        write_coeff(3'd0, 16'hC000);
        accept(16'h8000);
        wait_out(lat);
        total++;
        if (out_word !== 16'h7FFF || sat_flag !== 1'b1) begin
            bad++;
            $display("FAIL sat_pos: word=%0h sat=%0b want 7fff/1", out_word, sat_flag);
        end
        consume();
        hw_reset();
        write_coeff(3'd0, 16'd8192);
        accept(16'hFFFD);
        wait_out(lat);
        total++;
        if (out_word !== 16'hFFFE || sat_flag !== 1'b0) begin
            bad++;
            $display("FAIL floor_neg: word=%0h sat=%0b want fffe/0", out_word, sat_flag);
        end
        consume();
    endtask

    task automatic test_backpressure;
        int lat;
        hw_reset();
        write_coeff(3'd0, 16'd16384);
        out_ready = 1'b0;
        accept(16'd42);
        wait_out(lat);
        total++;
        if (out_word !== 16'd42 || out_last !== 1'b0 || sat_flag !== 1'b0) begin
            bad++;
            $display("FAIL bp_value: word=%0d last=%0b sat=%0b want 42/0/0", out_word, out_last, sat_flag);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin in_valid = 1'b1; in_word = 16'd999; end
            @(posedge clk30x);
            #1 in_valid = 1'b0;
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_word !== 16'd42 || out_last !== 1'b0 || sat_flag !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d]: valid=%0b ready=%0b word=%0d last=%0b sat=%0b want 1/0/42/0/0",
                         i, out_valid, in_ready, out_word, out_last, sat_flag);
            end
        end
        out_ready = 1'b1;
        @(posedge clk30x);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: valid=%0b ready=%0b want 0/1", out_valid, in_ready);
        end
        repeat (20) @(posedge clk30x);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_ignored_pulse: valid=%0b ready=%0b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_mult;
        int lat;
        logic seen;
        hw_reset();
        write_coeff(3'd0, 16'd16384);
        accept(16'd555);
        repeat (7) @(posedge clk30x);
        #1 reset = 1'b1;
        @(posedge clk30x);
        #1 reset = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_word !== 16'd0) begin
            bad++;
            $display("FAIL midreset_state: ready=%0b valid=%0b word=%0d want 1/0/0", in_ready, out_valid, out_word);
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk30x);
            #1 if (out_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL midreset_discard: out_valid seen=%0b want 0", seen); end
        accept(16'd1234);
        wait_out(lat);
        total++;
        if (out_word !== 16'd0 || sat_flag !== 1'b0) begin
            bad++;
            $display("FAIL midreset_coeff_cleared: word=%0d sat=%0b want 0/0", out_word, sat_flag);
        end
        consume();
    endtask

    task automatic test_coeff_write_in_flight;
        int lat;
        hw_reset();
        write_coeff(3'd0, 16'd16384);
        accept(16'd300);
        @(posedge clk30x);
        #1;
        write_coeff(3'd0, 16'd0);
        wait_out(lat);
        total++;
        if (out_word !== 16'd300) begin bad++; $display("FAIL inflight_word: got %0d want 300", out_word); end
        consume();
        start_index = 3'd1;
        accept(16'd500);
        wait_out(lat);
        total++;
        if (out_word !== 16'd0 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL new_window_word: word=%0d last=%0b want 0/0", out_word, out_last);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_unity_window();
        test_start_offset();
        test_signed_sat();
        test_backpressure();
        test_reset_mid_mult();
        test_coeff_write_in_flight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
